// File: rtl/cram_config_loader.sv
`default_nettype none
// ============================================================================
// cram_config_loader : byte-stream loader for the serial CRAM chain, with a
//                      CRC-8 recirculating readback check gating fabric reset
// Revision 1.0
// ============================================================================
module cram_config_loader #(
  parameter int CHAIN_LEN = 1024,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  output logic       s_ready,
  output logic       cram_en,
  output logic       cram_cfg_en,
  output logic       cram_data_out,
  input  logic       cram_data_in,
  output logic       le_nrst,
  output logic       le_en,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [7:0] crc
);

  if (CHAIN_LEN < 16 || (CHAIN_LEN % 8) != 0) begin : g_bad_chain_len
    $error("CHAIN_LEN must be a multiple of 8 and at least 16");
  end

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_VERIFY = 3'd2,
    S_CHECK  = 3'd3,
    S_DONE   = 3'd4,
    S_ERROR  = 3'd5
  } state_e;

  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(CHAIN_LEN - 1);
  localparam logic [CNT_W-1:0] NUM_BYTES = CNT_W'(CHAIN_LEN / 8);

  function automatic logic [7:0] crc8_step(input logic [7:0] c, input logic b);
    return {c[6:0], 1'b0} ^ ((c[7] ^ b) ? 8'h07 : 8'h00);
  endfunction

  state_e           state_q, state_d;
  logic [7:0]       buf_q;
  logic [3:0]       bcnt_q;
  logic [CNT_W-1:0] bitcnt_q;
  logic [CNT_W-1:0] bytes_q;
  logic [7:0]       lcrc_q;
  logic [7:0]       vcrc_q;
  logic             busy_q, done_q, error_q, le_q;

  logic w_shift, w_verify, w_accept, w_enter_load;

  assign w_shift  = (state_q == S_LOAD) && (bcnt_q != 4'd0);
  assign w_verify = (state_q == S_VERIFY);
  assign s_ready  = (state_q == S_LOAD) && (bcnt_q <= 4'd1) && (bytes_q < NUM_BYTES);
  assign w_accept = s_valid && s_ready;

  assign cram_en     = w_shift || w_verify;
  assign cram_cfg_en = w_shift || w_verify;
  // Recirculation is combinational so each VERIFY cycle rotates the chain by one.
  assign cram_data_out = w_verify ? cram_data_in : (w_shift & buf_q[7]);

  assign busy    = busy_q;
  assign done    = done_q;
  assign error   = error_q;
  assign le_nrst = le_q;
  assign le_en   = le_q;
  assign crc     = lcrc_q;

  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:   if (start) state_d = S_LOAD;
        S_LOAD:   if (w_shift && bitcnt_q == LAST_BIT) state_d = S_VERIFY;
        S_VERIFY: if (bitcnt_q == LAST_BIT) state_d = S_CHECK;
        S_CHECK:  state_d = (vcrc_q == lcrc_q) ? S_DONE : S_ERROR;
        S_DONE,
        S_ERROR:  if (start) state_d = S_LOAD;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  assign w_enter_load = (state_d == S_LOAD) && (state_q != S_LOAD);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q  <= S_IDLE;
      buf_q    <= 8'h00;
      bcnt_q   <= 4'd0;
      bitcnt_q <= '0;
      bytes_q  <= '0;
      lcrc_q   <= 8'h00;
      vcrc_q   <= 8'h00;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
      le_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d == S_LOAD) || (state_d == S_VERIFY) || (state_d == S_CHECK);
      done_q  <= (state_d == S_DONE);
      error_q <= (state_d == S_ERROR);
      le_q    <= (state_d == S_DONE);

      if (w_enter_load) begin
        buf_q    <= 8'h00;
        bcnt_q   <= 4'd0;
        bitcnt_q <= '0;
        bytes_q  <= '0;
        lcrc_q   <= 8'h00;
        vcrc_q   <= 8'h00;
      end else if (state_q == S_LOAD) begin
        if (w_shift) begin
          buf_q    <= {buf_q[6:0], 1'b0};
          bcnt_q   <= bcnt_q - 4'd1;
          // Wrap to zero on the last bit so VERIFY reuses the counter.
          bitcnt_q <= (bitcnt_q == LAST_BIT) ? '0 : bitcnt_q + CNT_W'(1);
          lcrc_q   <= crc8_step(lcrc_q, buf_q[7]);
        end
        if (w_accept) begin
          buf_q   <= s_data;
          bcnt_q  <= 4'd8;
          bytes_q <= bytes_q + CNT_W'(1);
        end
      end else if (w_verify) begin
        bitcnt_q <= bitcnt_q + CNT_W'(1);
        vcrc_q   <= crc8_step(vcrc_q, cram_data_in);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cram_config_loader.sv
`default_nettype none
// ============================================================================
// tb_cram_config_loader : directed bench with a fabric chain model and a
//                         bit-stream / CRC reference checked every cycle
// Revision 1.0
// ============================================================================
module tb_cram_config_loader;
  localparam int N = 16;

  logic       clk     = 1'b0;
  logic       nrst    = 1'b0;
  logic       start   = 1'b0;
  logic       abort   = 1'b0;
  logic [7:0] s_data  = 8'h00;
  logic       s_valid = 1'b0;
  logic       s_ready, cram_en, cram_cfg_en, cram_data_out, cram_data_in;
  logic       le_nrst, le_en, busy, done, error;
  logic [7:0] crc;

  always #5 clk = ~clk;

  cram_config_loader #(.CHAIN_LEN(N)) dut (
    .clk(clk), .nrst(nrst), .start(start), .abort(abort),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .cram_en(cram_en), .cram_cfg_en(cram_cfg_en),
    .cram_data_out(cram_data_out), .cram_data_in(cram_data_in),
    .le_nrst(le_nrst), .le_en(le_en), .busy(busy), .done(done),
    .error(error), .crc(crc)
  );

  // Fabric chain: shifts in at bit 0, reads out of the far end.
  logic [N-1:0] chain     = '0;
  int           fault_mode = 0;
  logic         flip_now   = 1'b0;
  always @(posedge clk) if (cram_cfg_en) chain <= {chain[N-2:0], cram_data_out};
  assign cram_data_in = (fault_mode == 2) ? 1'b0 : (chain[N-1] ^ flip_now);

  int           checks = 0, failures = 0, cyc = 0;
  int           en_cnt = 0, low_en = 0;
  bit           mon_on = 1'b0;
  logic [N-1:0] exp_stream = '0;
  logic [7:0]   tx_bytes [3];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] crc8_bytes(input logic [7:0] b0, input logic [7:0] b1);
    logic [7:0] c = 8'h00;
    logic [7:0] bb [2];
    bb[0] = b0; bb[1] = b1;
    for (int k = 0; k < 2; k++) begin
      c = c ^ bb[k];
      for (int j = 0; j < 8; j++) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
    return c;
  endfunction

  // Every cycle: invariants plus the expected bit on the chain input.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (mon_on) begin
      chk("en_pair", cram_en, cram_cfg_en);
      chk("le_gate", {le_nrst, le_en}, {done, done});
      chk("status_excl", (int'(busy) + int'(done) + int'(error)) <= 1, 1);
      if (busy && !cram_en) low_en++;
      if (cram_cfg_en) begin
        if (en_cnt < N) chk("load_bit", cram_data_out, exp_stream[N-1-en_cnt]);
        else if (en_cnt < 2*N && fault_mode == 0)
          chk("verify_bit", cram_data_out, exp_stream[2*N-1-en_cnt]);
        en_cnt++;
      end
    end
    flip_now = (fault_mode == 1) && (en_cnt == N + 3);
  endtask

  // intr: 0 none, 1 abort in VERIFY, 2 async reset in LOAD
  task automatic run_load(input int gap, input int fmode, input bit poke, input int intr);
    int idx = 0, acc = 0, gap_left = gap, t0;
    bit pend = 1'b0, ended = 1'b0;
    fault_mode = fmode;
    exp_stream = {tx_bytes[0], tx_bytes[1]};
    en_cnt = 0; low_en = 0; mon_on = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    t0 = cyc;
    chk("start_to_load", {busy, s_ready, le_nrst, le_en, done}, 5'b11000);
    for (int c = 0; c < 200 && !ended; c++) begin
      if (pend) idx++;
      if (idx == 1 && gap_left > 0 && s_ready) begin
        s_valid = 1'b0; gap_left--;
      end else if (idx < 3) begin
        s_valid = 1'b1; s_data = tx_bytes[idx];
      end else begin
        s_valid = 1'b0;
      end
      pend = s_valid && s_ready;
      if (pend) acc++;
      if (poke && (c == 6 || c == 20)) start = 1'b1;
      if (intr == 1 && c == 22) begin
        chk("abort_in_verify", en_cnt > N, 1);
        abort = 1'b1;
      end
      if (intr == 2 && c == 9) begin
        nrst = 1'b0;
        #1;
        chk("async_reset_outputs",
            {s_ready, cram_en, cram_cfg_en, cram_data_out, le_nrst, le_en, busy, done, error, crc}, 0);
        s_valid = 1'b0; mon_on = 1'b0;
        tick();
        nrst = 1'b1;
        tick();
        chk("idle_after_reset", {busy, s_ready, cram_en, done, error}, 0);
        return;
      end
      tick();
      start = 1'b0;
      if (abort) begin
        abort = 1'b0;
        chk("abort_idle", {busy, s_ready, cram_en, done, error}, 0);
        s_valid = 1'b0; mon_on = 1'b0;
        return;
      end
      if (done || error) ended = 1'b1;
    end
    s_valid = 1'b0;
    if (!ended) chk("timeout", 0, 1);
    chk("finish_latency", cyc - t0, 2*N + 2 + gap);
    chk("bytes_accepted", acc, N/8);
    chk("stall_cycles", low_en, 2 + gap);
    chk("crc_model", crc, crc8_bytes(tx_bytes[0], tx_bytes[1]));
    if (fmode == 0) begin
      chk("done_flags", {done, error, le_nrst, le_en}, 4'b1011);
      chk("chain_contents", chain, exp_stream);
    end else begin
      chk("error_flags", {done, error, le_nrst, le_en}, 4'b0100);
    end
  endtask

  initial begin
    tx_bytes[0] = 8'hA5; tx_bytes[1] = 8'h3C; tx_bytes[2] = 8'hFF;
    repeat (3) tick();
    chk("reset_outputs",
        {s_ready, cram_en, cram_cfg_en, cram_data_out, le_nrst, le_en, busy, done, error, crc}, 0);
    nrst = 1'b1;
    tick();
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("start_abort_idle", {busy, s_ready, cram_en}, 0);

    run_load(0, 0, 1'b0, 0);
    chk("crc_literal", crc, 8'hED);
    run_load(5, 0, 1'b0, 0);
    chk("crc_literal_stall", crc, 8'hED);
    run_load(0, 0, 1'b1, 0);
    run_load(0, 1, 1'b0, 0);
    run_load(0, 2, 1'b0, 0);
    chk("crc_literal_stuck", crc, 8'hED);
    run_load(0, 0, 1'b0, 1);
    run_load(0, 0, 1'b0, 2);
    run_load(0, 0, 1'b0, 0);
    chk("crc_literal_recover", crc, 8'hED);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cram_config_loader.md
# cram_config_loader

- Sequences the serial configuration RAM chain of the FPGA fabric.
- Accepts a bitstream as bytes over a valid/ready stream and shifts it bit-serially into the chain (cram_data_out drives the fabric's config_data_in).
- After the load, recirculates the whole chain once and checks a CRC-8 of the bits read back, leaving the chain unchanged.
- Holds the fabric logic (le_nrst/le_en) in reset until configuration has been verified.

## Interface
- CHAIN_LEN, 1024: total CRAM chain length in bits; must be a multiple of 8 and ≥ 16.
- CNT_W, $clog2(CHAIN_LEN+1): width of the bit counter.
- clk  in  1  single clock; shared with the fabric's clk.
- nrst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; starts load+verify from IDLE, DONE or ERROR; ignored otherwise.
- abort  in  1  returns to IDLE from any state on the next edge.
- s_data  in  8  bitstream byte, shifted MSB first.
- s_valid  in  1  s_data valid.
- s_ready  out  1  loader accepts s_data this cycle.
- cram_en  out  1  to fabric en.
- cram_cfg_en  out  1  to fabric config_en.
- cram_data_out  out  1  to fabric config_data_in.
- cram_data_in  in  1  from fabric config_data_out.
- le_nrst  out  1  fabric logic reset, active-low.
- le_en  out  1  fabric logic enable.
- busy  out  1  high in LOAD, VERIFY and CHECK.
- done  out  1  high in DONE.
- error  out  1  high in ERROR.
- crc  out  8  CRC-8 of the loaded bitstream, valid in DONE and ERROR.

## Operation
- States: IDLE, LOAD, VERIFY, CHECK, DONE, ERROR.
  - IDLE→LOAD on start.
  - LOAD→VERIFY after CHAIN_LEN bits have been shifted.
  - VERIFY→CHECK after CHAIN_LEN recirculated bits.
  - CHECK→DONE if the verify CRC equals the load CRC, otherwise CHECK→ERROR.
  - DONE or ERROR →LOAD on start.
  - abort from any state →IDLE.
- Entering LOAD clears the bit counter, both CRCs and the byte buffer.
- LOAD byte buffer:
  - 8-bit shift register plus a count of bits remaining (bcnt, 0..8).
  - s_ready = LOAD && (bcnt ≤ 1) && (bytes accepted < CHAIN_LEN/8).
  - On s_valid && s_ready: buffer loads s_data and bcnt becomes 8.
- Each LOAD cycle with bcnt ≠ 0:
  - cram_en = cram_cfg_en = 1 and cram_data_out = buffer[7].
  - Buffer shifts left, bcnt decrements, bit counter increments.
  - Load CRC is updated with the bit.
- VERIFY:
  - cram_en = cram_cfg_en = 1 every cycle.
  - cram_data_out = cram_data_in, a combinational recirculation path.
  - Verify CRC is updated with cram_data_in.
  - After exactly CHAIN_LEN cycles the chain holds its original contents.
  - The first bit read back is the first bit loaded.
- CRC-8:
  - Polynomial 0x07, init 0x00, bit-serial.
  - fb = crc[7] ^ bit; crc_next = {crc[6:0],1'b0} ^ (fb ? 8'h07 : 8'h00).
  - Equals the standard byte-wise MSB-first CRC-8.
- cram_en and cram_cfg_en are 0 in IDLE, CHECK, DONE and ERROR, and in LOAD while bcnt = 0 (stream starved).
- le_nrst = 1 and le_en = 1 only in DONE; both are 0 in every other state, including while reloading.
- start while busy is ignored. If start and abort occur together, abort wins.
- s_data is not sampled outside LOAD. Bytes offered beyond CHAIN_LEN/8 are not accepted (s_ready stays 0).

## Timing
- Reset values: state IDLE; s_ready, cram_en, cram_cfg_en, cram_data_out, le_nrst, le_en, busy, done and error all 0; crc 0x00.
- start at edge t: state is LOAD from t+1. s_ready is high in the t+1 cycle.
- A byte accepted at edge k has its bits on cram_data_out in cycles k+1..k+8.
- Back-to-back acceptance is possible in the cycle of the last bit, giving a sustained rate of 1 bit per clock.
- With s_valid held high:
  - LOAD lasts CHAIN_LEN+1 cycles.
  - VERIFY lasts CHAIN_LEN cycles.
  - CHECK lasts 1 cycle.
  - done rises 2·CHAIN_LEN+2 cycles after the start edge.
- A gap in s_valid stalls the chain shift with no bit skipped or duplicated. The bit counter counts only shifted bits.
- Asynchronous nrst mid-operation:
  - All outputs return immediately to their reset values.
  - Chain contents are undefined.
  - le_nrst stays 0 until a later load verifies.
- abort mid-LOAD or mid-VERIFY:
  - Chain contents are undefined.
  - crc holds a partial value, not valid.

## Test plan
- Load with CHAIN_LEN=16, bytes 0xA5 then 0x3C, s_valid always high:
  - cram_data_out carries 1010010100111100 on consecutive cycles.
  - crc=0xED; done rises 34 cycles after start; le_nrst=le_en=1; the model chain equals the loaded bits.
- Same load with s_valid dropped for 5 cycles between the bytes:
  - cram_en is low for the stall cycles; the shifted bit sequence is identical.
  - crc=0xED; done rises 5 cycles later.
- Fabric model flips one chain bit during VERIFY: error=1, done=0, le_nrst=0.
- Fabric model stuck-at-0 on config_data_out: ERROR state reached; crc still 0xED.
- Reset and abort:
  - nrst asserted at cycle 10 of LOAD: all outputs are 0 in the same cycle, and state is IDLE after release.
  - abort in VERIFY: state is IDLE the next cycle.
- Reconfiguration: start in DONE drops le_nrst and le_en the next cycle and runs a full new load; start while busy has no effect.
